// File: rtl/dds_sweep_gen.sv
// Linear tuning-word sweep generator feeding the AD9850 serial loader.
// Each word is offered over valid/ready, held for a dwell time, then stepped (single-shot or looping).
module dds_sweep_gen #(
  parameter int         TW_WIDTH    = 32,
  parameter int         STEP_WIDTH  = 16,
  parameter int         DWELL_WIDTH = 24,
  parameter logic [7:0] CTRL_BYTE   = 8'h00
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   continuous,
  input  logic                   dir_down,
  input  logic [TW_WIDTH-1:0]    start_tw,
  input  logic [TW_WIDTH-1:0]    step_tw,
  input  logic [STEP_WIDTH-1:0]  num_steps,
  input  logic [DWELL_WIDTH-1:0] dwell_cycles,
  output logic [TW_WIDTH-1:0]    tw_data,
  output logic [7:0]             ctrl_data,
  output logic                   tw_valid,
  input  logic                   tw_ready,
  output logic                   busy,
  output logic                   done,
  output logic [STEP_WIDTH-1:0]  step_idx
);

  typedef enum logic [1:0] {S_IDLE, S_PRESENT, S_DWELL, S_DONE} state_t;

  localparam logic [STEP_WIDTH-1:0]  IDX_ONE   = STEP_WIDTH'(1);
  localparam logic [DWELL_WIDTH-1:0] DWELL_ONE = DWELL_WIDTH'(1);

  state_t                 state;
  logic                   cont_q;
  logic                   down_q;
  logic [TW_WIDTH-1:0]    start_tw_q;
  logic [TW_WIDTH-1:0]    step_tw_q;
  logic [STEP_WIDTH-1:0]  last_idx_q;
  logic [DWELL_WIDTH-1:0] dwell_q;
  logic [DWELL_WIDTH-1:0] dwell_cnt;
  logic                   take_start;

  // Modulo-2^TW_WIDTH step; wrap-around is the intended behaviour.
  function automatic logic [TW_WIDTH-1:0] step_word(input logic [TW_WIDTH-1:0] tw,
                                                    input logic [TW_WIDTH-1:0] step,
                                                    input logic                down);
    return down ? (tw - step) : (tw + step);
  endfunction

  assign ctrl_data  = CTRL_BYTE;
  assign take_start = (state == S_IDLE) && start && !abort;

  // Configuration snapshot, frozen for the whole sweep.
  always_ff @(posedge clk) begin
    if (take_start) begin
      cont_q     <= continuous;
      down_q     <= dir_down;
      start_tw_q <= start_tw;
      step_tw_q  <= step_tw;
      last_idx_q <= (num_steps == '0) ? '0 : (num_steps - IDX_ONE);
      dwell_q    <= dwell_cycles;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      tw_data   <= '0;
      tw_valid  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      step_idx  <= '0;
      dwell_cnt <= '0;
    end else begin
      done <= 1'b0;
      if (abort && (state != S_IDLE)) begin
        state    <= S_IDLE;
        tw_valid <= 1'b0;
        busy     <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (take_start) begin
              tw_data  <= start_tw;
              step_idx <= '0;
              busy     <= 1'b1;
              state    <= S_PRESENT;
            end
          end
          // First PRESENT cycle after start raises valid; later words arrive with valid already set.
          S_PRESENT: begin
            if (!tw_valid) begin
              tw_valid <= 1'b1;
            end else if (tw_ready) begin
              tw_valid  <= 1'b0;
              dwell_cnt <= dwell_q;
              state     <= S_DWELL;
            end
          end
          S_DWELL: begin
            if (dwell_cnt == '0) begin
              if (step_idx != last_idx_q) begin
                tw_data  <= step_word(tw_data, step_tw_q, down_q);
                step_idx <= step_idx + IDX_ONE;
                tw_valid <= 1'b1;
                state    <= S_PRESENT;
              end else if (cont_q) begin
                tw_data  <= start_tw_q;
                step_idx <= '0;
                tw_valid <= 1'b1;
                state    <= S_PRESENT;
              end else begin
                done  <= 1'b1;
                state <= S_DONE;
              end
            end else begin
              dwell_cnt <= dwell_cnt - DWELL_ONE;
            end
          end
          S_DONE: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dds_sweep_gen.sv
// Bench for dds_sweep_gen: timeline reference model checked every cycle,
// directed sweeps with literal expectations, then randomized traffic.
module tb_dds_sweep_gen;

  localparam int TW = 32;
  localparam int SW = 16;
  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          reset, start, abort, continuous, dir_down, tw_ready;
  logic [TW-1:0] start_tw, step_tw;
  logic [SW-1:0] num_steps;
  logic [DW-1:0] dwell_cycles;
  logic [TW-1:0] tw_data;
  logic [7:0]    ctrl_data;
  logic          tw_valid, busy, done;
  logic [SW-1:0] step_idx;

  dds_sweep_gen dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .continuous(continuous), .dir_down(dir_down),
    .start_tw(start_tw), .step_tw(step_tw), .num_steps(num_steps),
    .dwell_cycles(dwell_cycles), .tw_data(tw_data), .ctrl_data(ctrl_data),
    .tw_valid(tw_valid), .tw_ready(tw_ready), .busy(busy), .done(done),
    .step_idx(step_idx)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: word sequence and event timing derived from the sweep rules.
  bit            m_busy = 0, m_valid = 0, m_done = 0, m_first = 0;
  logic [TW-1:0] m_word = '0;
  int            m_idx = 0, m_wait = 0;
  logic [TW-1:0] c_start, c_step;
  int            c_n, c_dwell;
  bit            c_cont, c_down;

  always @(posedge clk) begin
    if (reset) begin
      m_busy = 0; m_valid = 0; m_done = 0; m_first = 0;
      m_word = '0; m_idx = 0; m_wait = 0;
    end else if (m_busy && abort) begin
      m_busy = 0; m_valid = 0; m_done = 0; m_wait = 0;
    end else if (m_done) begin
      m_done = 0; m_busy = 0;
    end else if (!m_busy) begin
      if (start && !abort) begin
        c_start = start_tw; c_step = step_tw;
        c_n     = (num_steps == 0) ? 1 : int'(num_steps);
        c_dwell = int'(dwell_cycles);
        c_cont  = continuous; c_down = dir_down;
        m_busy = 1; m_first = 1; m_wait = 1;
        m_word = start_tw; m_idx = 0;
      end
    end else if (m_valid) begin
      if (tw_ready) begin
        m_valid = 0;
        m_wait  = c_dwell + 1;
      end
    end else if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 0) begin
        if (m_first) begin
          m_first = 0; m_valid = 1;
        end else if (m_idx < c_n - 1) begin
          m_word  = c_down ? (m_word - c_step) : (m_word + c_step);
          m_idx++;
          m_valid = 1;
        end else if (c_cont) begin
          m_word = c_start; m_idx = 0; m_valid = 1;
        end else begin
          m_done = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("tw_valid", tw_valid, m_valid);
      check("busy", busy, m_busy);
      check("done", done, m_done);
      check("step_idx", step_idx, m_idx);
      check("ctrl_data", ctrl_data, 8'h00);
      if (m_valid) check("tw_data", tw_data, m_word);
    end
  end

  // Event log for the directed checks.
  int            cyc = 0, st_cyc = 0, done_cyc = 0, done_cnt = 0;
  logic [TW-1:0] hs_q[$];
  int            hs_idx[$];
  int            hs_cyc[$];

  always @(posedge clk) begin
    if (tw_valid && tw_ready) begin
      hs_q.push_back(tw_data);
      hs_idx.push_back(int'(step_idx));
      hs_cyc.push_back(cyc);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (start && !busy && !abort && !reset) st_cyc = cyc;
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    hs_q.delete(); hs_idx.delete(); hs_cyc.delete();
    done_cnt = 0;
  endtask

  task automatic run_cfg(input logic [TW-1:0] s, input logic [TW-1:0] st, input int n,
                         input int dw, input bit cont, input bit down);
    start_tw = s; step_tw = st; num_steps = SW'(n); dwell_cycles = DW'(dw);
    continuous = cont; dir_down = down;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int k = 0;
    while (busy && k < budget) begin
      tick();
      k++;
    end
    check(name, busy, 1'b0);
  endtask

  logic [TW-1:0] exp5[5];
  int            k;

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; continuous = 1'b0; dir_down = 1'b0;
    tw_ready = 1'b0; start_tw = '0; step_tw = '0; num_steps = '0; dwell_cycles = '0;
    repeat (3) tick();
    check("rst_tw_data", tw_data, 32'h0);
    check("rst_tw_valid", tw_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_step_idx", step_idx, 16'h0);
    check("rst_ctrl", ctrl_data, 8'h00);
    chk_en = 1'b1;
    reset = 1'b0;
    tick();

    // Basic three-word sweep with ready held high.
    tw_ready = 1'b1;
    clear_log();
    run_cfg(32'h28F5C28F, 32'h01000000, 3, 4, 0, 0);
    wait_idle(200, "t1_timeout");
    check("t1_count", hs_q.size(), 3);
    if (hs_q.size() == 3) begin
      check("t1_w0", hs_q[0], 32'h28F5C28F);
      check("t1_w1", hs_q[1], 32'h29F5C28F);
      check("t1_w2", hs_q[2], 32'h2AF5C28F);
      check("t1_start_lat", hs_cyc[0] - st_cyc, 2);
      check("t1_hs_to_valid", hs_cyc[1] - hs_cyc[0], 6);
    end
    check("t1_done_cnt", done_cnt, 1);
    tick();

    // Wrap-around upward and downward.
    clear_log();
    run_cfg(32'hFFFFFFF0, 32'h20, 2, 1, 0, 0);
    wait_idle(100, "t2u_timeout");
    check("t2u_count", hs_q.size(), 2);
    if (hs_q.size() == 2) check("t2u_wrap", hs_q[1], 32'h00000010);
    clear_log();
    run_cfg(32'h00000010, 32'h20, 2, 1, 0, 1);
    wait_idle(100, "t2d_timeout");
    check("t2d_count", hs_q.size(), 2);
    if (hs_q.size() == 2) check("t2d_wrap", hs_q[1], 32'hFFFFFFF0);

    // Back-pressure: word held until ready, dwell only afterwards.
    tw_ready = 1'b0;
    clear_log();
    run_cfg(32'h12345678, 32'h100, 1, 3, 0, 0);
    repeat (22) tick();
    check("t3_valid_held", tw_valid, 1'b1);
    check("t3_data_held", tw_data, 32'h12345678);
    check("t3_no_hs", hs_q.size(), 0);
    tw_ready = 1'b1;
    wait_idle(100, "t3_timeout");
    check("t3_count", hs_q.size(), 1);
    if (hs_q.size() == 1) check("t3_dwell_after_ready", done_cyc - hs_cyc[0], 5);
    check("t3_done_cnt", done_cnt, 1);

    // Abort during the dwell after step 1; abort+start in IDLE.
    clear_log();
    run_cfg(32'h00001000, 32'h10, 3, 10, 0, 0);
    k = 0;
    while (hs_q.size() < 2 && k < 100) begin
      tick();
      k++;
    end
    check("t4_reach_step1", hs_q.size(), 2);
    repeat (2) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t4_abort_busy", busy, 1'b0);
    check("t4_abort_valid", tw_valid, 1'b0);
    check("t4_abort_done", done, 1'b0);
    repeat (15) tick();
    check("t4_no_done", done_cnt, 0);
    check("t4_no_more_words", hs_q.size(), 2);
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    check("t4_abort_start_busy", busy, 1'b0);
    tick();
    check("t4_abort_start_valid", tw_valid, 1'b0);

    // Continuous two-word loop.
    clear_log();
    run_cfg(32'hA0000000, 32'h01234567, 2, 2, 1, 0);
    k = 0;
    while (hs_q.size() < 5 && k < 200) begin
      tick();
      k++;
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    exp5 = '{32'hA0000000, 32'hA1234567, 32'hA0000000, 32'hA1234567, 32'hA0000000};
    check("t5_count", hs_q.size() >= 5, 1'b1);
    if (hs_q.size() >= 5) begin
      for (int i = 0; i < 5; i++) begin
        check($sformatf("t5_w%0d", i), hs_q[i], exp5[i]);
        check($sformatf("t5_idx%0d", i), hs_idx[i], i % 2);
      end
    end
    check("t5_no_done", done_cnt, 0);

    // num_steps=0 and dwell=0; a second start while busy is ignored.
    clear_log();
    run_cfg(32'h55555555, 32'h1, 0, 0, 0, 0);
    start_tw = 32'h77777777; start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle(50, "t6_timeout");
    check("t6_count", hs_q.size(), 1);
    if (hs_q.size() == 1) begin
      check("t6_word", hs_q[0], 32'h55555555);
      check("t6_one_dwell", done_cyc - hs_cyc[0], 2);
    end
    check("t6_done_cnt", done_cnt, 1);
    repeat (3) tick();
    check("t6_still_idle", busy, 1'b0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      reset        = ($urandom_range(0, 499) == 0);
      start        = ($urandom_range(0, 9) == 0);
      abort        = ($urandom_range(0, 49) == 0);
      tw_ready     = ($urandom_range(0, 9) < 7);
      continuous   = ($urandom_range(0, 3) == 0);
      dir_down     = $urandom_range(0, 1);
      start_tw     = $urandom;
      step_tw      = $urandom;
      num_steps    = SW'($urandom_range(0, 4));
      dwell_cycles = DW'($urandom_range(0, 4));
      tick();
    end
    reset = 1'b0; start = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    check("final_idle", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
